// File: rtl/uart_tx_fifo_feeder_if.sv
// ============================================================================
// Module      : uart_tx_fifo_feeder_if
// Description : Host write port plus TX-core issue port of the FIFO feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_fifo_feeder_if #(
  parameter int DATA_SIZE  = 8,
  parameter int DEPTH_LOG2 = 3
);
  logic                  WR_EN;
  logic [DATA_SIZE-1:0]  WR_DATA;
  logic                  FLUSH;
  logic                  Busy_TX;
  logic                  FULL;
  logic                  EMPTY;
  logic [DEPTH_LOG2:0]   COUNT;
  logic                  OVERFLOW;
  logic [DATA_SIZE-1:0]  P_DATA;
  logic                  Data_Valid;

  // master: host plus TX core environment; slave: the feeder itself
  modport master (
    output WR_EN, WR_DATA, FLUSH, Busy_TX,
    input  FULL, EMPTY, COUNT, OVERFLOW, P_DATA, Data_Valid
  );

  modport slave (
    input  WR_EN, WR_DATA, FLUSH, Busy_TX,
    output FULL, EMPTY, COUNT, OVERFLOW, P_DATA, Data_Valid
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo_feeder.sv
// ============================================================================
// Module      : uart_tx_fifo_feeder
// Description : Host-side byte FIFO that issues one byte per TX frame,
//               pacing itself off the TX core's registered Busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_feeder #(
  parameter int DATA_SIZE  = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  wire logic             CLK_FSM,
  input  wire logic             RST_FSM,
  uart_tx_fifo_feeder_if.slave  bus
);

  localparam int c_depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_ptr_one = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_overflow;
  logic                  r_data_valid;
  logic [DATA_SIZE-1:0]  r_p_data;
  logic [DATA_SIZE-1:0]  r_mem [c_depth];

  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DEPTH_LOG2:0]   w_wr_ptr_nxt;
  logic [DEPTH_LOG2:0]   w_rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic [DEPTH_LOG2-1:0] w_wr_addr;
  logic [DEPTH_LOG2-1:0] w_rd_addr;

  assign w_wr_addr = r_wr_ptr[DEPTH_LOG2-1:0];
  assign w_rd_addr = r_rd_ptr[DEPTH_LOG2-1:0];

  // A pop frees the slot being written, so a full FIFO still accepts a write
  // on the pop edge; FLUSH discards both.
  always_comb begin
    w_pop        = (r_state == IDLE) && !r_empty && !bus.Busy_TX && !bus.FLUSH;
    w_push       = bus.WR_EN && (!r_full || w_pop) && !bus.FLUSH;
    w_drop       = bus.WR_EN && r_full && !w_pop;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (bus.FLUSH) begin
      w_rd_ptr_nxt = r_wr_ptr;
    end else begin
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;
      end
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + c_ptr_one;
      end
    end
    w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
  end

  always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
    if (!RST_FSM) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_empty    <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_full     <= (w_wr_ptr_nxt[DEPTH_LOG2-1:0] == w_rd_ptr_nxt[DEPTH_LOG2-1:0]) &&
                    (w_wr_ptr_nxt[DEPTH_LOG2] != w_rd_ptr_nxt[DEPTH_LOG2]);
      r_overflow <= w_drop;
    end
  end

  always_ff @(posedge CLK_FSM) begin
    if (w_push) begin
      r_mem[w_wr_addr] <= bus.WR_DATA;
    end
  end

  // P_DATA only moves on an issue, so it is stable for the whole frame.
  always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
    if (!RST_FSM) begin
      r_state      <= IDLE;
      r_data_valid <= 1'b0;
      r_p_data     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_p_data     <= r_mem[w_rd_addr];
            r_data_valid <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_data_valid <= 1'b0;
          r_state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.Busy_TX) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.Busy_TX) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_data_valid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.FULL       = r_full;
  assign bus.EMPTY      = r_empty;
  assign bus.COUNT      = r_count;
  assign bus.OVERFLOW   = r_overflow;
  assign bus.P_DATA     = r_p_data;
  assign bus.Data_Valid = r_data_valid;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_feeder.sv
// ============================================================================
// Module      : tb_uart_tx_fifo_feeder
// Description : Randomised scoreboard bench with a queue-based feeder model
//               and a behavioural TX core that answers Data_Valid with Busy.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_fifo_feeder;

  localparam int DATA_SIZE  = 8;
  localparam int DEPTH_LOG2 = 3;
  localparam int c_depth    = 2 ** DEPTH_LOG2;

  logic CLK_FSM = 1'b0;
  logic RST_FSM = 1'b0;

  uart_tx_fifo_feeder_if #(.DATA_SIZE(DATA_SIZE), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_tx_fifo_feeder #(.DATA_SIZE(DATA_SIZE), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .CLK_FSM (CLK_FSM),
    .RST_FSM (RST_FSM),
    .bus     (bus)
  );

  always #5 CLK_FSM = ~CLK_FSM;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // TX core: Busy rises 2 edges after it samples Data_Valid, then stays high
  // for frame_len cycles.
  int   frame_len = 4;
  int   r_left;
  logic r_p1, r_p2;
  always @(posedge CLK_FSM or negedge RST_FSM) begin
    if (!RST_FSM) begin
      r_p1        <= 1'b0;
      r_p2        <= 1'b0;
      r_left      <= 0;
      bus.Busy_TX <= 1'b0;
    end else begin
      r_p1 <= bus.Data_Valid;
      r_p2 <= r_p1;
      if (r_p2) begin
        bus.Busy_TX <= 1'b1;
        r_left      <= frame_len;
      end else if (bus.Busy_TX) begin
        if (r_left <= 1) bus.Busy_TX <= 1'b0;
        else             r_left      <= r_left - 1;
      end
    end
  end

  // Reference model: a byte queue plus frames-issued / frames-completed
  // counts; a byte may go out only when every issued frame has finished.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         issued, completed;
  logic       prev_busy;
  logic       m_dv, m_ovf;
  logic [7:0] m_pdata;

  always @(posedge CLK_FSM or negedge RST_FSM) begin
    if (!RST_FSM) begin
      mq.delete();
      exp_q.delete();
      issued    = 0;
      completed = 0;
      prev_busy = 1'b0;
      m_dv      = 1'b0;
      m_ovf     = 1'b0;
      m_pdata   = 8'h00;
    end else begin
      logic pop, was_full;
      was_full = (mq.size() == c_depth);
      pop      = (issued == completed) && (mq.size() > 0) && !bus.Busy_TX && !bus.FLUSH;
      m_ovf    = bus.WR_EN && was_full && !pop;
      m_dv     = pop;
      if (bus.FLUSH) begin
        mq.delete();
      end else begin
        if (pop) begin
          m_pdata = mq.pop_front();
          exp_q.push_back(m_pdata);
          issued++;
        end
        if (bus.WR_EN && (!was_full || pop)) mq.push_back(bus.WR_DATA);
      end
      if (prev_busy && !bus.Busy_TX) completed++;
      prev_busy = bus.Busy_TX;
    end
  end

  // Cycle checker on flags and strobes
  always @(negedge CLK_FSM) begin
    check("count",    32'(bus.COUNT),      32'(mq.size()));
    check("empty",    32'(bus.EMPTY),      32'(mq.size() == 0));
    check("full",     32'(bus.FULL),       32'(mq.size() == c_depth));
    check("overflow", 32'(bus.OVERFLOW),   32'(m_ovf));
    check("dv",       32'(bus.Data_Valid), 32'(m_dv));
    check("p_data",   32'(bus.P_DATA),     32'(m_pdata));
  end

  // Scoreboard monitor: each issue strobe consumes one expected byte
  always @(negedge CLK_FSM) begin
    if (RST_FSM && bus.Data_Valid) begin
      check("sb_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("sb_byte", 32'(bus.P_DATA), 32'(exp_q.pop_front()));
    end
  end

  task automatic cycle();
    @(negedge CLK_FSM);
  endtask

  task automatic write(input logic [7:0] d);
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = d;
    cycle();
    bus.WR_EN   = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int max);
    for (int i = 0; i < max && bus.Busy_TX !== lvl; i++) cycle();
    check("wait_busy", 32'(bus.Busy_TX), 32'(lvl));
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && !(mq.size() == 0 && issued == completed && !bus.Busy_TX); i++)
      cycle();
    check("drain", 32'(mq.size() + (issued - completed)), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, 32'(bus.EMPTY),      32'd1);
    check({tag, "_full"},  32'(bus.FULL),       32'd0);
    check({tag, "_count"}, 32'(bus.COUNT),      32'd0);
    check({tag, "_dv"},    32'(bus.Data_Valid), 32'd0);
    check({tag, "_pdata"}, 32'(bus.P_DATA),     32'd0);
    check({tag, "_ovf"},   32'(bus.OVERFLOW),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = 8'h00;
    bus.FLUSH   = 1'b0;
    RST_FSM     = 1'b0;
    repeat (3) cycle();
    check_reset_outputs("t1");
    RST_FSM = 1'b1;
    cycle();

    // single byte
    write(8'hA5);
    wait_drain(100);
    check("t2_empty", 32'(bus.EMPTY),  32'd1);
    check("t2_pdata", 32'(bus.P_DATA), 32'h0000_00A5);

    // burst into a busy core fills the FIFO
    frame_len = 30;
    write(8'h00);
    wait_busy(1'b1, 20);
    for (int i = 1; i <= 8; i++) write(8'(i));
    check("t3_full",  32'(bus.FULL),  32'd1);
    check("t3_count", 32'(bus.COUNT), 32'd8);

    // overflow while full and busy
    write(8'hFF);
    check("t4_ovf",   32'(bus.OVERFLOW), 32'd1);
    check("t4_count", 32'(bus.COUNT),    32'd8);
    cycle();
    check("t4_ovf_clr", 32'(bus.OVERFLOW), 32'd0);

    // write on the pop edge of a full FIFO
    frame_len = 5;
    for (int i = 0; i < 100 && !(issued == completed && mq.size() > 0 && !bus.Busy_TX); i++)
      cycle();
    write(8'h55);
    check("t5_count", 32'(bus.COUNT),      32'd8);
    check("t5_ovf",   32'(bus.OVERFLOW),   32'd0);
    check("t5_dv",    32'(bus.Data_Valid), 32'd1);
    wait_drain(1000);
    check("t5_last", 32'(bus.P_DATA), 32'h0000_0055);

    // flush mid-frame: queued bytes vanish, in-flight frame completes
    frame_len = 20;
    write(8'h11);
    wait_busy(1'b1, 20);
    write(8'h22);
    write(8'h33);
    bus.FLUSH = 1'b1;
    cycle();
    bus.FLUSH = 1'b0;
    check("t5_flush_count", 32'(bus.COUNT), 32'd0);
    check("t5_flush_busy",  32'(bus.Busy_TX), 32'd1);
    wait_drain(100);
    check("t5_flush_pdata", 32'(bus.P_DATA), 32'h0000_0011);

    // async reset in WAIT_DONE
    write(8'h77);
    wait_busy(1'b1, 20);
    repeat (3) cycle();
    #2;
    RST_FSM = 1'b0;
    #1;
    check_reset_outputs("t6");
    cycle();
    RST_FSM = 1'b1;
    cycle();
    frame_len = 4;
    write(8'h3C);
    wait_drain(100);
    check("t6_pdata", 32'(bus.P_DATA), 32'h0000_003C);

    // randomised traffic
    for (int c = 0; c < 400; c++) begin
      int r;
      r         = $urandom_range(0, 99);
      frame_len = $urandom_range(1, 6);
      bus.FLUSH   = (r < 3);
      bus.WR_EN   = (r >= 3) && (r < 60);
      bus.WR_DATA = 8'($urandom);
      cycle();
    end
    bus.FLUSH = 1'b0;
    bus.WR_EN = 1'b0;
    wait_drain(2000);
    repeat (3) cycle();
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
